// File: rtl/matrix_pkg.sv
// Shared constants for the matrix bank: default geometry, reset contents of
// the two preloaded slots and the default result-register address.
package matrix_pkg;
  localparam int DEF_ELEM_W = 16;
  localparam int DEF_DIM    = 4;
  localparam int DEF_MAT_W  = DEF_ELEM_W * DEF_DIM * DEF_DIM;

  localparam logic [7:0] DEF_RESULT_ADDR = 8'hFF;

  localparam logic [DEF_MAT_W-1:0] INIT_SLOT0 =
    256'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210_0F1E_2D3C_4B5A_6978_8796_A5B4_C3D2_E1F0;
  localparam logic [DEF_MAT_W-1:0] INIT_SLOT1 =
    256'hDEAD_BEEF_CAFE_F00D_1234_5678_9ABC_DEF0_0000_FFFF_5555_AAAA_3333_CCCC_0F0F_F0F0;
endpackage

// File: rtl/matrix_transpose.sv
// Combinational DIM x DIM transpose: output element (r,c) takes input element (c,r).
module matrix_transpose #(
  parameter int ELEM_W = 16,
  parameter int DIM    = 4,
  localparam int MAT_W = ELEM_W * DIM * DIM
) (
  input  logic [MAT_W-1:0] i_mat,
  output logic [MAT_W-1:0] o_mat
);
  for (genvar r = 0; r < DIM; r++) begin : g_row
    for (genvar c = 0; c < DIM; c++) begin : g_col
      assign o_mat[(r*DIM+c)*ELEM_W +: ELEM_W] = i_mat[(c*DIM+r)*ELEM_W +: ELEM_W];
    end
  end
endmodule

// File: rtl/matrix_bank_mem.sv
// Banked matrix store with a dedicated result register, optional transpose on
// both write and read, and a one-deep registered valid/ready response stage.
module matrix_bank_mem
  import matrix_pkg::*;
#(
  parameter int ELEM_W = DEF_ELEM_W,
  parameter int DIM    = DEF_DIM,
  parameter int DEPTH  = 12,
  parameter int ADDR_W = 8,
  parameter logic [ADDR_W-1:0] RESULT_ADDR = ADDR_W'(DEF_RESULT_ADDR),
  localparam int MAT_W = ELEM_W * DIM * DIM
) (
  input  logic              clk,
  input  logic              nReset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic              req_transpose,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [MAT_W-1:0]  req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [MAT_W-1:0]  rsp_rdata,
  output logic              rsp_err
);
  logic [MAT_W-1:0] r_mem [DEPTH];
  logic [MAT_W-1:0] r_result;
  logic             r_rsp_valid;
  logic [MAT_W-1:0] r_rsp_rdata;
  logic             r_rsp_err;

  logic [DEPTH-1:0] w_slot_hit;
  logic             w_is_result;
  logic             w_addr_ok;
  logic             w_accept;
  logic [MAT_W-1:0] w_rd_mat;
  logic [MAT_W-1:0] w_rd_t;
  logic [MAT_W-1:0] w_wr_t;
  logic [MAT_W-1:0] w_rd_out;
  logic [MAT_W-1:0] w_wr_in;

  assign req_ready = !r_rsp_valid || rsp_ready;
  assign w_accept  = req_valid && req_ready;

  // The result register wins over a slot that happens to share its address.
  assign w_is_result = (req_addr == RESULT_ADDR);
  assign w_addr_ok   = w_is_result || (|w_slot_hit);

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      w_slot_hit[i] = (req_addr == ADDR_W'(i));
    end
  end

  always_comb begin
    w_rd_mat = r_result;
    if (!w_is_result) begin
      w_rd_mat = '0;
      for (int i = 0; i < DEPTH; i++) begin
        if (w_slot_hit[i]) w_rd_mat = r_mem[i];
      end
    end
  end

  matrix_transpose #(.ELEM_W(ELEM_W), .DIM(DIM)) u_rd_transpose (
    .i_mat (w_rd_mat),
    .o_mat (w_rd_t)
  );

  matrix_transpose #(.ELEM_W(ELEM_W), .DIM(DIM)) u_wr_transpose (
    .i_mat (req_wdata),
    .o_mat (w_wr_t)
  );

  assign w_rd_out = req_transpose ? w_rd_t : w_rd_mat;
  assign w_wr_in  = req_transpose ? w_wr_t : req_wdata;

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
      r_result    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= (i == 0) ? MAT_W'(INIT_SLOT0) :
                    (i == 1) ? MAT_W'(INIT_SLOT1) : '0;
      end
    end else begin
      if (w_accept) begin
        r_rsp_valid <= 1'b1;
        r_rsp_err   <= !w_addr_ok;
        r_rsp_rdata <= (req_write || !w_addr_ok) ? '0 : w_rd_out;
        if (req_write && w_is_result) r_result <= w_wr_in;
        for (int i = 0; i < DEPTH; i++) begin
          if (req_write && w_slot_hit[i] && !w_is_result) r_mem[i] <= w_wr_in;
        end
      end else if (rsp_ready) begin
        r_rsp_valid <= 1'b0;
      end
    end
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;
endmodule

// File: tb/tb_matrix_bank_mem.sv
// Randomised scoreboard bench for matrix_bank_mem against an array-based model.
module tb_matrix_bank_mem;
  import matrix_pkg::*;

  localparam int MW = 256;

  logic          clk = 1'b0;
  logic          nReset = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_write = 1'b0;
  logic          req_transpose = 1'b0;
  logic [7:0]    req_addr = '0;
  logic [MW-1:0] req_wdata = '0;
  logic          rsp_ready = 1'b0;
  logic          req_ready;
  logic          rsp_valid;
  logic          rsp_err;
  logic [MW-1:0] rsp_rdata;

  matrix_bank_mem dut (
    .clk           (clk),
    .nReset        (nReset),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_write     (req_write),
    .req_transpose (req_transpose),
    .req_addr      (req_addr),
    .req_wdata     (req_wdata),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_rdata     (rsp_rdata),
    .rsp_err       (rsp_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int rs_mode = 1;            // 0: hold off, 1: always ready, 2: random
  logic [MW:0]   exp_q[$];    // {err, rdata}
  logic [MW-1:0] model [0:12]; // index 12 is the result register

  always @(negedge clk) begin
    case (rs_mode)
      0: rsp_ready = 1'b0;
      1: rsp_ready = 1'b1;
      default: rsp_ready = ($urandom_range(0, 3) != 0);
    endcase
  end

  task automatic check(input string name, input logic [MW-1:0] act, input logic [MW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic int map_addr(input logic [7:0] a);
    if (a == 8'hFF) return 12;
    if (a < 8'd12) return int'(a);
    return -1;
  endfunction

  function automatic logic [MW-1:0] transpose(input logic [MW-1:0] m);
    logic [MW-1:0] o;
    o = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        o[(r*4+c)*16 +: 16] = m[(c*4+r)*16 +: 16];
    return o;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 13; i++) model[i] = '0;
    model[0] = INIT_SLOT0;
    model[1] = INIT_SLOT1;
  endtask

  task automatic issue(input bit w, input bit t, input logic [7:0] a,
                       input logic [MW-1:0] d, output int waited);
    int idx;
    bit ok;
    @(negedge clk);
    req_valid = 1'b1; req_write = w; req_transpose = t; req_addr = a; req_wdata = d;
    waited = 0;
    ok = 1'b1;
    #2;
    while (!req_ready) begin
      if (waited >= 50) begin
        n_cmp++; n_bad++;
        $display("FAIL req_ready_timeout: got 0 expected 1 within 50 cycles");
        ok = 1'b0;
        break;
      end
      @(negedge clk); #2;
      waited++;
    end
    if (ok) begin
      idx = map_addr(a);
      if (idx < 0) exp_q.push_back({1'b1, {MW{1'b0}}});
      else if (w) begin
        model[idx] = t ? transpose(d) : d;
        exp_q.push_back({1'b0, {MW{1'b0}}});
      end else
        exp_q.push_back({1'b0, t ? transpose(model[idx]) : model[idx]});
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
  endtask

  // Monitor: compares each consumed response and checks that stalled ones hold.
  initial begin
    logic          held;
    logic [MW-1:0] h_data;
    logic          h_err;
    logic [MW:0]   e;
    held = 1'b0; h_data = '0; h_err = 1'b0;
    forever begin
      @(negedge clk); #2;
      if (nReset && rsp_valid) begin
        if (held) begin
          check("hold_rdata", rsp_rdata, h_data);
          check("hold_err", MW'(rsp_err), MW'(h_err));
        end
        if (rsp_ready) begin
          if (exp_q.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL unexpected_rsp: got rdata %h expected no response", rsp_rdata);
          end else begin
            e = exp_q.pop_front();
            check("rsp_rdata", rsp_rdata, e[MW-1:0]);
            check("rsp_err", MW'(rsp_err), MW'(e[MW]));
          end
        end
      end
      held = nReset && rsp_valid && !rsp_ready;
      h_data = rsp_rdata;
      h_err = rsp_err;
    end
  end

  initial begin
    int wt, wt2, waitc;
    logic [MW-1:0] d;
    logic [7:0] a;
    model_reset();
    rs_mode = 1;

    #12;
    check("reset_rsp_valid", MW'(rsp_valid), '0);
    check("reset_rsp_err", MW'(rsp_err), '0);
    check("reset_rsp_rdata", rsp_rdata, '0);
    @(negedge clk); nReset = 1'b1;
    #2 check("ready_after_reset", MW'(req_ready), MW'(1));

    // Read preloaded slot 0 and confirm single-cycle latency.
    issue(1'b0, 1'b0, 8'd0, '0, wt);
    check("read_latency", MW'(rsp_valid), MW'(1));
    issue(1'b0, 1'b0, 8'd1, '0, wt);

    // Counting pattern, then transposed and plain reads.
    d = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) d[(r*4+c)*16 +: 16] = 16'(r*4+c);
    issue(1'b1, 1'b0, 8'd3, d, wt);
    issue(1'b0, 1'b1, 8'd3, '0, wt);
    issue(1'b0, 1'b0, 8'd3, '0, wt);
    issue(1'b1, 1'b1, 8'd4, d, wt);
    issue(1'b0, 1'b0, 8'd4, '0, wt);

    // Result register, invalid address, slots untouched.
    issue(1'b1, 1'b0, 8'hFF, MW'(1), wt);
    issue(1'b0, 1'b0, 8'hFF, '0, wt);
    issue(1'b1, 1'b0, 8'd12, {MW{1'b1}}, wt);
    issue(1'b0, 1'b0, 8'd12, '0, wt);
    for (int i = 0; i < 12; i++) issue(1'b0, 1'b0, 8'(i), '0, wt);

    // Backpressure: stall three cycles, then accept alongside consumption.
    repeat (3) @(negedge clk);
    rs_mode = 0;
    issue(1'b0, 1'b0, 8'd0, '0, wt);
    repeat (3) begin
      @(negedge clk); #2;
      check("ready_low_stall", MW'(req_ready), '0);
    end
    rs_mode = 1;
    issue(1'b0, 1'b0, 8'd1, '0, wt);
    check("b2b_accept_wait", MW'(wt), '0);

    // Back-to-back write then read, one per cycle.
    issue(1'b1, 1'b0, 8'd5, MW'(8'hA5), wt);
    issue(1'b0, 1'b0, 8'd5, '0, wt2);
    check("b2b_write_wait", MW'(wt), '0);
    check("b2b_read_wait", MW'(wt2), '0);

    // Reset while a response is pending.
    repeat (3) @(negedge clk);
    rs_mode = 0;
    issue(1'b0, 1'b0, 8'd5, '0, wt);
    check("pending_before_reset", MW'(rsp_valid), MW'(1));
    #2 nReset = 1'b0;
    #1;
    check("async_rst_valid", MW'(rsp_valid), '0);
    check("async_rst_rdata", rsp_rdata, '0);
    exp_q.delete();
    model_reset();
    repeat (2) @(negedge clk);
    nReset = 1'b1;
    rs_mode = 1;
    #2 check("ready_after_rst2", MW'(req_ready), MW'(1));
    issue(1'b0, 1'b0, 8'd5, '0, wt);
    issue(1'b0, 1'b0, 8'd0, '0, wt);

    // Randomised traffic with random response backpressure.
    rs_mode = 2;
    for (int n = 0; n < 400; n++) begin
      case ($urandom_range(0, 5))
        0: a = 8'hFF;
        1: a = 8'($urandom);
        2: a = 8'($urandom_range(12, 15));
        default: a = 8'($urandom_range(0, 11));
      endcase
      for (int k = 0; k < 8; k++) d[k*32 +: 32] = $urandom;
      issue(1'($urandom), 1'($urandom), a, d, wt);
    end

    rs_mode = 1;
    waitc = 0;
    while (exp_q.size() != 0 && waitc < 100) begin
      @(negedge clk);
      waitc++;
    end
    #3;
    check("drain_queue", MW'(exp_q.size()), '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
